approx_mul_accumulator: RTL and testbench
=========================================

# approx_mul_accumulator

Streaming accumulator that sits directly downstream of the unsigned 8x8 approximate multipliers. It consumes their 16-bit products over a valid/ready handshake and adds an optional per-product bias to compensate the multiplier's systematic error. It sums a packet of products delimited by `in_last` into a wide accumulator and presents the packet result, product count and overflow flag on a registered valid/ready output.

## Interface
Parameters:
- `ACC_W`, default 24: accumulator and result width; must be at least 17.
- `LEN_W`, default 8: width of the saturating product counter.
- `BIAS`, default 0: unsigned 16-bit constant added to every accepted product. It is an error-compensation term for the approximate multiplier.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_z`  in  16  unsigned product from the multiplier.
- `in_last`  in  1  beat is the final product of the packet.
- `clr`  in  1  synchronous discard of the partial packet.
- `out_valid`  out  1  packet result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  ACC_W  packet sum, modulo 2^ACC_W.
- `out_count`  out  LEN_W  number of beats in the packet, saturating.
- `out_ovf`  out  1  sticky: sum carried out of ACC_W during the packet.

## Operation
- Two states: ACCUM (reset state) and HOLD.
- `in_ready` = (state == ACCUM), decoded from registered state.
- A beat is accepted when `in_valid && in_ready`.
- Term per beat: `t = {0,in_z} + BIAS`, computed at ACC_W+1 bits.

On an accepted beat in ACCUM:
- `acc <= acc + t`, keeping the low ACC_W bits.
- Any carry out of ACC_W sets `ovf`; `ovf` stays set until the packet is released.
- `count <= count + 1`, saturating at 2^LEN_W−1.
- If `in_last` is set, the accumulator is updated with this beat and the state goes to HOLD.

`clr` in ACCUM:
- Without an accepted beat: `acc`, `count` and `ovf` go to 0.
- With an accepted beat in the same cycle: the new packet starts from that beat, so `acc = t`, `count = 1`, and `ovf` = carry of t alone (always 0 when ACC_W ≥ 17). `in_last` on that beat applies normally.

In HOLD:
- `out_valid = 1`; `out_acc`, `out_count` and `out_ovf` come straight from `acc`, `count` and `ovf`.
- All outputs are stable until `out_ready` is sampled high.
- `clr` is ignored.
- On `out_valid && out_ready`: `acc`, `count` and `ovf` clear to 0 and the state returns to ACCUM.

In ACCUM, `out_valid = 0`; `out_acc`, `out_count` and `out_ovf` reflect the running partial values and must not be used.

## Timing
- Reset (asynchronous): state = ACCUM, `acc` = 0, `count` = 0, `ovf` = 0.
  - Output values: `in_ready` = 1, `out_valid` = 0, `out_acc` = 0, `out_count` = 0, `out_ovf` = 0.
- Reset asserted mid-packet or in HOLD discards everything; no output is produced for that packet.
- Throughput: one beat per cycle while in ACCUM.
- Latency: last beat accepted at edge t → `out_valid` = 1 from t, i.e. visible in cycle t+1.
- Release at edge r (`out_ready` high):
  - `in_ready` = 1 from cycle r+1.
  - No input beat is accepted in the release cycle.
  - Minimum gap between packets is one cycle.
- A single-beat packet (`in_last` on the first beat) is legal; it yields `out_count` = 1.
- The arithmetic is fully combinational into the `acc` register; there are no extra pipeline stages.

## Test plan
- **Basic sum.** BIAS=0; beats 100, 200, 300, with last on the third, all back-to-back.
  - `out_valid` rises the cycle after the third accept.
  - `out_acc` = 600, `out_count` = 3, `out_ovf` = 0, `in_ready` = 0 while held.
- **Bias.** BIAS=3; beats 10, 20 (last).
  - `out_acc` = 36, `out_count` = 2.
- **Overflow and saturation.** Defaults; 257 beats of 0xFFFF, last on beat 257.
  - `out_acc` = 16842495 mod 2^24 = 65279.
  - `out_ovf` = 1, `out_count` = 255.
  - A 256-beat packet of 0xFFFF gives 16776960 with `out_ovf` = 0 and `out_count` = 255.
- **Backpressure.** Hold `out_ready` low for 5 cycles after `out_valid`.
  - Outputs stay stable and `in_ready` stays 0.
  - `in_valid` beats are not accepted.
  - After release, the next packet of 7 (last) gives `out_acc` = 7, `out_count` = 1.
- **Clear.** Beats 50, 60, then `clr` with no beat, then 5 (last): `out_acc` = 5, `out_count` = 1.
  - Repeat with `clr` coincident with beat 9 (last): `out_acc` = 9, `out_count` = 1.
  - `clr` pulsed during HOLD has no effect.
- **Reset mid-packet.** Assert `rst_n` low asynchronously after 2 beats.
  - Outputs go to reset values immediately.
  - After deassert, the packet 4, 4 (last) yields 8.

Source files
------------

// File: rtl/approx_mul_accumulator.sv
// Streaming packet accumulator for approximate-multiplier products with bias compensation.
module approx_mul_accumulator #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 8,
    parameter logic [15:0] BIAS  = 16'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_z,
    input  logic             in_last,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [LEN_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic [SUM_W-1:0]   term;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_base;
    logic [LEN_W-1:0]   count_base;
    logic               ovf_base;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath logic; clr restarts the packet from the current beat.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        accept     = 1'b0;
        term       = SUM_W'(in_z) + SUM_W'(BIAS);
        acc_base   = acc_q;
        count_base = count_q;
        ovf_base   = ovf_q;
        sum        = '0;

        case (state_q)
            ACCUM: begin
                accept = in_valid;
                if (clr) begin
                    acc_base   = '0;
                    count_base = '0;
                    ovf_base   = 1'b0;
                end
                sum = {1'b0, acc_base} + term;
                if (accept) begin
                    acc_d   = sum[ACC_W-1:0];
                    ovf_d   = ovf_base | sum[ACC_W];
                    count_d = (count_base == {LEN_W{1'b1}}) ? count_base
                                                            : count_base + LEN_W'(1);
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end else begin
                    acc_d   = acc_base;
                    count_d = count_base;
                    ovf_d   = ovf_base;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Handshake flags decode the registered state; result ports mirror the registers.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_approx_mul_accumulator.sv
// Directed bench for approx_mul_accumulator with hand-computed expectations.
module tb_approx_mul_accumulator;

    localparam int unsigned ACC_W = 24;
    localparam int unsigned LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_z;
    logic             in_last;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [LEN_W-1:0] out_count;
    logic             out_ovf;

    logic             b_in_valid;
    logic             b_in_ready;
    logic [15:0]      b_in_z;
    logic             b_in_last;
    logic             b_out_valid;
    logic             b_out_ready;
    logic [ACC_W-1:0] b_out_acc;
    logic [LEN_W-1:0] b_out_count;
    logic             b_out_ovf;

    int n_cmp;
    int n_bad;

    approx_mul_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W), .BIAS(16'd0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .in_last   (in_last),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    approx_mul_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W), .BIAS(16'd3)) dut_bias (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_z      (b_in_z),
        .in_last   (b_in_last),
        .clr       (1'b0),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_acc   (b_out_acc),
        .out_count (b_out_count),
        .out_ovf   (b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One beat presented for one clock edge; sampled 1 time unit after the edge.
    task automatic beat(input logic [15:0] z, input logic last);
        in_valid = 1'b1;
        in_z     = z;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_pkt();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_z = '0; in_last = 1'b0; clr = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_z = '0; b_in_last = 1'b0; b_out_ready = 1'b0;

        #2;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_acc", 32'(out_acc), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_ovf", 32'(out_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic sum
        beat(16'd100, 1'b0);
        beat(16'd200, 1'b0);
        check("basic_valid_early", 32'(out_valid), 0);
        beat(16'd300, 1'b1);
        check("basic_valid", 32'(out_valid), 1);
        check("basic_acc", 32'(out_acc), 600);
        check("basic_count", 32'(out_count), 3);
        check("basic_ovf", 32'(out_ovf), 0);
        check("basic_in_ready", 32'(in_ready), 0);
        release_pkt();
        check("basic_rel_valid", 32'(out_valid), 0);
        check("basic_rel_ready", 32'(in_ready), 1);
        check("basic_rel_acc", 32'(out_acc), 0);

        // Bias on second instance
        b_in_valid = 1'b1; b_in_z = 16'd10; b_in_last = 1'b0;
        @(posedge clk); #1;
        b_in_z = 16'd20; b_in_last = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
        check("bias_valid", 32'(b_out_valid), 1);
        check("bias_acc", 32'(b_out_acc), 36);
        check("bias_count", 32'(b_out_count), 2);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        check("bias_rel_valid", 32'(b_out_valid), 0);

        // Overflow with saturation: 257 x 0xFFFF
        for (int i = 0; i < 257; i++) beat(16'hFFFF, (i == 256));
        check("ovf_valid", 32'(out_valid), 1);
        check("ovf_acc", 32'(out_acc), 65279);
        check("ovf_flag", 32'(out_ovf), 1);
        check("ovf_count", 32'(out_count), 255);
        release_pkt();
        check("ovf_rel_flag", 32'(out_ovf), 0);

        // Boundary: 256 x 0xFFFF fits
        for (int i = 0; i < 256; i++) beat(16'hFFFF, (i == 255));
        check("fit_acc", 32'(out_acc), 16776960);
        check("fit_flag", 32'(out_ovf), 0);
        check("fit_count", 32'(out_count), 255);
        release_pkt();

        // Backpressure with beats offered while held
        beat(16'd1, 1'b0);
        beat(16'd2, 1'b1);
        in_valid = 1'b1; in_z = 16'd77; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 1);
            check("bp_acc", 32'(out_acc), 3);
            check("bp_count", 32'(out_count), 2);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        in_z = 16'd7;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_rel_valid", 32'(out_valid), 0);
        check("bp_rel_acc", 32'(out_acc), 0);
        check("bp_rel_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_next_valid", 32'(out_valid), 1);
        check("bp_next_acc", 32'(out_acc), 7);
        check("bp_next_count", 32'(out_count), 1);
        release_pkt();

        // Clear without a beat, then clr pulsed in HOLD
        beat(16'd50, 1'b0);
        beat(16'd60, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_acc", 32'(out_acc), 0);
        check("clr_count", 32'(out_count), 0);
        beat(16'd5, 1'b1);
        check("clr_pkt_acc", 32'(out_acc), 5);
        check("clr_pkt_count", 32'(out_count), 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_hold_valid", 32'(out_valid), 1);
        check("clr_hold_acc", 32'(out_acc), 5);
        check("clr_hold_count", 32'(out_count), 1);
        release_pkt();

        // Clear coincident with a last beat
        beat(16'd50, 1'b0);
        beat(16'd60, 1'b0);
        clr = 1'b1;
        beat(16'd9, 1'b1);
        clr = 1'b0;
        check("clrb_valid", 32'(out_valid), 1);
        check("clrb_acc", 32'(out_acc), 9);
        check("clrb_count", 32'(out_count), 1);
        release_pkt();

        // Asynchronous reset mid-packet
        beat(16'd11, 1'b0);
        beat(16'd22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_acc", 32'(out_acc), 0);
        check("arst_count", 32'(out_count), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(16'd4, 1'b0);
        beat(16'd4, 1'b1);
        check("arst_pkt_valid", 32'(out_valid), 1);
        check("arst_pkt_acc", 32'(out_acc), 8);
        check("arst_pkt_count", 32'(out_count), 2);
        release_pkt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit guards against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
